// File: rtl/turnstile_pkg.sv
// Shared types and constants for the turnstile gate controller.
//   gate_state_t : controller FSM states
//   REQ_COIN/REQ_CARD : requester indices into req/grant
//   NUM_REQ : number of fare sources sharing the gate
package turnstile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } gate_state_t;

    localparam int REQ_COIN = 0;
    localparam int REQ_CARD = 1;
    localparam int NUM_REQ  = 2;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req    : request levels, bit0 coin, bit1 card
//   ptr    : requester favoured when both are asking
//   winner : chosen requester index
//   valid  : at least one request is present
module rr_arb2
    import turnstile_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic               winner,
    output logic               valid
);

    always_comb begin
        valid  = |req;
        winner = ptr;
        case (req)
            2'b01:   winner = 1'(REQ_COIN);
            2'b10:   winner = 1'(REQ_CARD);
            default: winner = ptr;
        endcase
    end

endmodule

// File: rtl/turnstile_gate_ctrl.sv
// Turnstile gate controller shared between the coin acceptor and card reader.
// Arbitrates fare requests round-robin, grants the winner for one cycle,
// holds the gate open for up to OPEN_TICKS divider ticks and closes on
// passage or timeout.
//
// Optional feature: define TURNSTILE_TIMEOUT_CNT_EN to add timeout_count,
// a saturating count of expired windows.
//
// Ports:
//   clk, reset (async, active-low)
//   tick       : divider enable pulse
//   req[1:0]   : fare request levels (bit0 coin, bit1 card)
//   pass       : passage sensor pulse
//   grant[1:0] : one-hot one-cycle grant
//   gate_open  : gate unlocked
//   busy       : controller not idle
//   owner      : current/last granted requester
//   remaining  : ticks left in the open window, 0 outside OPEN
//   pass_count : saturating passage count
//   timeout    : pulse when a window expires with no passage
//
// state | meaning
// IDLE  | waiting for a fare request
// GRANT | one-cycle grant pulse, timer loaded
// OPEN  | gate unlocked, timer counting ticks
// CLOSE | gate locked, round-robin pointer handed to the other requester
module turnstile_gate_ctrl
    import turnstile_pkg::*;
#(
    parameter logic [3:0] OPEN_TICKS = 4'd8,
    parameter int         CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [NUM_REQ-1:0] req,
    input  logic               pass,
    output logic [NUM_REQ-1:0] grant,
    output logic               gate_open,
    output logic               busy,
    output logic               owner,
    output logic [3:0]         remaining,
    output logic [CNT_W-1:0]   pass_count,
    output logic               timeout
`ifdef TURNSTILE_TIMEOUT_CNT_EN
    ,
    output logic [CNT_W-1:0]   timeout_count
`endif
);

    gate_state_t state_q, state_d;
    logic        owner_q, owner_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  timer_q, timer_d;
    logic [CNT_W-1:0] pass_count_q;
    logic        pass_inc;
    logic        arb_winner;
    logic        arb_valid;

    rr_arb2 u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            timer_q <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        grant     = '0;
        gate_open = 1'b0;
        timeout   = 1'b0;
        pass_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                grant   = owner_q ? 2'b10 : 2'b01;
                timer_d = OPEN_TICKS;
                state_d = OPEN;
            end
            OPEN: begin
                gate_open = 1'b1;
                if (tick) begin
                    timer_d = timer_q - 4'd1;
                end
                // A passage in the expiring cycle still counts as a passage.
                if (pass) begin
                    pass_inc = 1'b1;
                    state_d  = CLOSE;
                end else if (tick && timer_q == 4'd1) begin
                    timeout = 1'b1;
                    state_d = CLOSE;
                end
            end
            CLOSE: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_count_q <= '0;
        end else if (pass_inc && (pass_count_q != '1)) begin
            pass_count_q <= pass_count_q + 1'b1;
        end
    end

`ifdef TURNSTILE_TIMEOUT_CNT_EN
    logic [CNT_W-1:0] timeout_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_count_q <= '0;
        end else if (timeout && (timeout_count_q != '1)) begin
            timeout_count_q <= timeout_count_q + 1'b1;
        end
    end

    assign timeout_count = timeout_count_q;
`endif

    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;
    assign remaining  = (state_q == OPEN) ? timer_q : 4'd0;
    assign pass_count = pass_count_q;

endmodule

// File: doc/turnstile_gate_ctrl.md
Name: turnstile_gate_ctrl

Overview:
Controller that shares the single turnstile gate mechanism between two fare sources: coin acceptor (requester 0) and card reader (requester 1).
- Round-robin arbitration between the two requests.
- One-cycle grant handshake to the winner.
- Unlocks the gate for a bounded number of divider ticks, then closes on passage or timeout.
- Outputs feed the existing seven-segment coder path: remaining-time digit and passenger count.

Parameters:
OPEN_TICKS, 4'd8, gate-open window in tick pulses; legal range 1..15.
CNT_W, 8, width of passenger counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick  input  1  one-cycle enable pulse from the clock divider
req  input  2  fare requests; bit0 coin, bit1 card; level, held until granted
pass  input  1  one-cycle pulse from the passage sensor
grant  output  2  one-hot, one-cycle grant pulse
gate_open  output  1  gate unlocked
busy  output  1  high in any state other than IDLE
owner  output  1  index of the current or last granted requester
remaining  output  4  ticks left in the open window; 0 when not OPEN
pass_count  output  CNT_W  completed passages, saturating
timeout  output  1  one-cycle pulse when the window expires without a passage

Behaviour:
Reset (reset=0, asynchronous):
- State IDLE; all outputs 0.
- Round-robin pointer favours requester 0.
- pass_count cleared.

FSM states: IDLE, GRANT, OPEN, CLOSE. All transitions are on rising clk edges.

IDLE:
- req==0: stay in IDLE.
- Any req bit set: choose the winner and go to GRANT.
- Single request: that requester wins.
- Both requests: the requester indicated by the pointer wins.
- owner is latched to the winner.

GRANT (one cycle):
- grant[owner]=1.
- Load the timer with OPEN_TICKS.
- Go to OPEN.
- Requester must drop req the cycle after grant. req is sampled only in IDLE.

OPEN:
- gate_open=1; remaining = timer value.
- On a tick cycle, the timer decrements.
- pass=1: go to CLOSE; pass_count increments, saturating at all-ones.
- tick=1 with timer==1 and pass=0: timer reaches 0, go to CLOSE, timeout=1 that cycle.
- pass and expiring tick in the same cycle: pass wins, count increments, no timeout.
- Latency: a pass or expiry sampled at edge N drops gate_open at edge N.

CLOSE (one cycle):
- gate_open=0.
- Pointer set to the requester other than owner.
- Go to IDLE.

Other rules:
- pass outside OPEN is ignored; counter unchanged.
- tick outside OPEN is ignored.
- reset asserted mid-window closes the gate immediately, asynchronously.
- Worst-case grant-to-grant spacing with continuous requests is 2 + window + 1 cycles. The two requesters alternate strictly when both hold req.

Optional Feature:
Macro: TURNSTILE_TIMEOUT_CNT_EN
- Defined:
  - Adds output timeout_count [CNT_W-1:0].
  - Increments, saturating, on every timeout pulse.
  - Cleared by reset.
- Undefined: the port and the register are absent; all other behaviour is identical.

Decomposition:
Package turnstile_pkg holds:
- State enum gate_state_t {IDLE, GRANT, OPEN, CLOSE}.
- Constants REQ_COIN=0 and REQ_CARD=1.
- Constant NUM_REQ=2.

One sub-module, rr_arb2:
- Combinational 2-way round-robin pick from req and the pointer.
- Outputs the winner index and a valid flag.
- The pointer register stays in turnstile_gate_ctrl.

Test Plan:
- Reset: hold reset=0 with req=2'b11 → all outputs 0; release → grant=2'b01 on the second edge (pointer favours coin).
- Both requesting continuously, pass one cycle after each gate_open → grants alternate 01,10,01,10; pass_count = 4 after four windows.
- req=2'b10 alone, OPEN_TICKS=3, no pass, three ticks → remaining 3,2,1; timeout pulse on the third tick; gate_open=0; pass_count unchanged.
- pass coincident with the final expiring tick → pass_count +1, timeout stays 0, state goes to CLOSE.
- pass pulses in IDLE, and reset=0 during OPEN with remaining=5 → counter unchanged by IDLE pulses; gate_open falls without a clk edge.
- CNT_W=2 with 5 passages → pass_count saturates at 3. With TURNSTILE_TIMEOUT_CNT_EN defined and 2 expiries → timeout_count=2.
